// File: rtl/fifo_sync_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : fifo_sync_ctrl_if
// Desc     : Request/response and status bundle for the single-clock FIFO.
// Revision : 1.0
// ============================================================================
interface fifo_sync_ctrl_if #(
    parameter int ADDRESS_SIZE = 4,
    parameter int DATA_WIDTH   = 8
);
    logic                    w_en;
    logic [DATA_WIDTH-1:0]   w_data;
    logic                    r_en;
    logic [DATA_WIDTH-1:0]   r_data;
    logic                    r_valid;
    logic [ADDRESS_SIZE:0]   af_level;
    logic [ADDRESS_SIZE:0]   ae_level;
    logic                    clr_err;
    logic                    w_full;
    logic                    w_almost_full;
    logic                    r_empty;
    logic                    r_almost_empty;
    logic [ADDRESS_SIZE:0]   count;
    logic [ADDRESS_SIZE:0]   w_ptr;
    logic [ADDRESS_SIZE:0]   r_ptr;
    logic                    w_overflow;
    logic                    r_underflow;

    modport master (
        output w_en, w_data, r_en, af_level, ae_level, clr_err,
        input  r_data, r_valid, w_full, w_almost_full, r_empty, r_almost_empty,
               count, w_ptr, r_ptr, w_overflow, r_underflow
    );

    modport slave (
        input  w_en, w_data, r_en, af_level, ae_level, clr_err,
        output r_data, r_valid, w_full, w_almost_full, r_empty, r_almost_empty,
               count, w_ptr, r_ptr, w_overflow, r_underflow
    );
endinterface
`default_nettype wire

// File: rtl/fifo_sync_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fifo_sync_ctrl
// Desc     : Single-clock FIFO with registered flags, occupancy count,
//            Gray-coded pointer export and sticky overflow/underflow.
// Revision : 1.0
// ============================================================================
module fifo_sync_ctrl #(
    parameter int ADDRESS_SIZE = 4,
    parameter int DATA_WIDTH   = 8
) (
    input  wire              clk,
    input  wire              rst,
    fifo_sync_ctrl_if.slave  bus
);
    localparam int DEPTH = 1 << ADDRESS_SIZE;
    localparam logic [ADDRESS_SIZE:0] C_DEPTH = {1'b1, {ADDRESS_SIZE{1'b0}}};
    localparam logic [ADDRESS_SIZE:0] C_ONE   = {{ADDRESS_SIZE{1'b0}}, 1'b1};

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [ADDRESS_SIZE:0]  wbin_q, wbin_d, rbin_q, rbin_d;
    logic [ADDRESS_SIZE:0]  wgray_q, wgray_d, rgray_q, rgray_d;
    logic [ADDRESS_SIZE:0]  count_q, count_d;
    logic                   full_q, full_d, empty_q, empty_d;
    logic                   afull_q, afull_d, aempty_q, aempty_d;
    logic                   ovf_q, ovf_d, unf_q, unf_d;
    logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;
    logic                   rvalid_q, rvalid_d;
    logic                   wacc, racc;

    // Acceptance uses only registered flags, so no request reaches an output
    // combinationally and simultaneous requests at full/empty resolve cleanly.
    always_comb begin
        wacc     = bus.w_en & ~full_q;
        racc     = bus.r_en & ~empty_q;
        wbin_d   = wacc ? wbin_q + C_ONE : wbin_q;
        rbin_d   = racc ? rbin_q + C_ONE : rbin_q;
        count_d  = count_q;
        case ({wacc, racc})
            2'b10:   count_d = count_q + C_ONE;
            2'b01:   count_d = count_q - C_ONE;
            default: count_d = count_q;
        endcase
        full_d   = (count_d == C_DEPTH);
        empty_d  = (count_d == '0);
        afull_d  = (count_d >= bus.af_level);
        aempty_d = (count_d <= bus.ae_level);
        wgray_d  = wbin_d ^ (wbin_d >> 1);
        rgray_d  = rbin_d ^ (rbin_d >> 1);
        // A new error in the same cycle as clr_err wins.
        ovf_d    = (ovf_q & ~bus.clr_err) | (bus.w_en & full_q);
        unf_d    = (unf_q & ~bus.clr_err) | (bus.r_en & empty_q);
        rdata_d  = racc ? mem[rbin_q[ADDRESS_SIZE-1:0]] : rdata_q;
        rvalid_d = racc;
    end

    always_ff @(posedge clk) begin
        if (!rst && wacc) begin
            mem[wbin_q[ADDRESS_SIZE-1:0]] <= bus.w_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wbin_q   <= '0;
            rbin_q   <= '0;
            wgray_q  <= '0;
            rgray_q  <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            wbin_q   <= wbin_d;
            rbin_q   <= rbin_d;
            wgray_q  <= wgray_d;
            rgray_q  <= rgray_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            afull_q  <= afull_d;
            aempty_q <= aempty_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

    assign bus.r_data         = rdata_q;
    assign bus.r_valid        = rvalid_q;
    assign bus.w_full         = full_q;
    assign bus.r_empty        = empty_q;
    assign bus.w_almost_full  = afull_q;
    assign bus.r_almost_empty = aempty_q;
    assign bus.count          = count_q;
    assign bus.w_ptr          = wgray_q;
    assign bus.r_ptr          = rgray_q;
    assign bus.w_overflow     = ovf_q;
    assign bus.r_underflow    = unf_q;
endmodule
`default_nettype wire

// File: tb/tb_fifo_sync_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_sync_ctrl
// Desc     : Directed and randomized bench with a queue-based occupancy model.
// Revision : 1.0
// ============================================================================
module tb_fifo_sync_ctrl;
    localparam int AS    = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 1 << AS;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fifo_sync_ctrl_if #(.ADDRESS_SIZE(AS), .DATA_WIDTH(DW)) bus ();

    fifo_sync_ctrl #(.ADDRESS_SIZE(AS), .DATA_WIDTH(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: a queue of words plus the few registered side values.
    logic [DW-1:0] q[$];
    int            m_wp, m_rp;
    logic [DW-1:0] m_rdata;
    bit            m_rvalid, m_af, m_ae, m_ovf, m_unf;

    function automatic void chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic int gray(input int b);
        return b ^ (b >> 1);
    endfunction

    task automatic model_step();
        int sz;
        bit wacc, racc;
        if (rst) begin
            q.delete();
            m_wp = 0; m_rp = 0; m_rdata = '0; m_rvalid = 0;
            m_af = 0; m_ae = 1; m_ovf = 0; m_unf = 0;
            return;
        end
        sz   = q.size();
        wacc = bus.w_en && (sz != DEPTH);
        racc = bus.r_en && (sz != 0);
        m_ovf = (m_ovf && !bus.clr_err) || (bus.w_en && sz == DEPTH);
        m_unf = (m_unf && !bus.clr_err) || (bus.r_en && sz == 0);
        m_rvalid = racc;
        if (racc) begin
            m_rdata = q.pop_front();
            m_rp = (m_rp + 1) % (2 * DEPTH);
        end
        if (wacc) begin
            q.push_back(bus.w_data);
            m_wp = (m_wp + 1) % (2 * DEPTH);
        end
        m_af = (q.size() >= int'(bus.af_level));
        m_ae = (q.size() <= int'(bus.ae_level));
    endtask

    task automatic check_all();
        chk("count",          int'(bus.count),          q.size());
        chk("w_full",         int'(bus.w_full),         int'(q.size() == DEPTH));
        chk("r_empty",        int'(bus.r_empty),        int'(q.size() == 0));
        chk("w_almost_full",  int'(bus.w_almost_full),  int'(m_af));
        chk("r_almost_empty", int'(bus.r_almost_empty), int'(m_ae));
        chk("r_valid",        int'(bus.r_valid),        int'(m_rvalid));
        chk("r_data",         int'(bus.r_data),         int'(m_rdata));
        chk("w_ptr",          int'(bus.w_ptr),          gray(m_wp));
        chk("r_ptr",          int'(bus.r_ptr),          gray(m_rp));
        chk("w_overflow",     int'(bus.w_overflow),     int'(m_ovf));
        chk("r_underflow",    int'(bus.r_underflow),    int'(m_unf));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic drive(input bit w, input bit r, input logic [DW-1:0] d, input bit c);
        bus.w_en = w; bus.r_en = r; bus.w_data = d; bus.clr_err = c;
        cycle();
    endtask

    initial begin
        bus.w_en = 0; bus.r_en = 0; bus.w_data = '0; bus.clr_err = 0;
        bus.af_level = 5'd12; bus.ae_level = 5'd2;
        rst = 1;
        cycle();
        cycle();
        chk("reset_count", int'(bus.count), 0);
        chk("reset_empty", int'(bus.r_empty), 1);
        chk("reset_aempty", int'(bus.r_almost_empty), 1);
        rst = 0;

        // Fill with 0x00..0x0F, then one refused write.
        for (int i = 0; i < DEPTH; i++) begin
            drive(1, 0, DW'(i), 0);
            chk("fill_afull_lit", int'(bus.w_almost_full), int'(i + 1 >= 12));
        end
        chk("full_count_lit", int'(bus.count), 16);
        chk("full_flag_lit", int'(bus.w_full), 1);
        drive(1, 0, 8'hEE, 0);
        chk("ovf_lit", int'(bus.w_overflow), 1);
        chk("ovf_count_lit", int'(bus.count), 16);

        // Drain in order, then one refused read.
        for (int i = 0; i < DEPTH; i++) begin
            drive(0, 1, 8'h00, 0);
            chk("drain_data_lit", int'(bus.r_data), i);
            chk("drain_valid_lit", int'(bus.r_valid), 1);
            chk("drain_aempty_lit", int'(bus.r_almost_empty), int'(DEPTH - 1 - i <= 2));
        end
        chk("empty_lit", int'(bus.r_empty), 1);
        drive(0, 1, 8'h00, 0);
        chk("unf_lit", int'(bus.r_underflow), 1);
        chk("unf_valid_lit", int'(bus.r_valid), 0);
        drive(0, 0, 8'h00, 1);
        chk("clr_lit", int'(bus.w_overflow) + int'(bus.r_underflow), 0);

        // Simultaneous requests at full and at empty.
        for (int i = 0; i < DEPTH; i++) drive(1, 0, DW'(8'h40 + i), 0);
        drive(1, 1, 8'h99, 0);
        chk("both_full_count_lit", int'(bus.count), 15);
        chk("both_full_data_lit", int'(bus.r_data), 8'h40);
        chk("both_full_ovf_lit", int'(bus.w_overflow), 1);
        for (int i = 0; i < 15; i++) drive(0, 1, 8'h00, 0);
        drive(1, 1, 8'h77, 1);
        chk("both_empty_count_lit", int'(bus.count), 1);
        chk("both_empty_valid_lit", int'(bus.r_valid), 0);

        // Stream 40 words at constant occupancy 3.
        drive(1, 0, 8'h78, 0);
        drive(1, 0, 8'h79, 0);
        for (int i = 0; i < 40; i++) drive(1, 1, DW'($urandom), 0);
        chk("stream_count_lit", int'(bus.count), 3);

        // Randomized traffic with phase-biased request rates and moving levels.
        for (int i = 0; i < 1500; i++) begin
            int ph = (i / 60) % 3;
            int wp = (ph == 0) ? 85 : (ph == 1) ? 25 : 55;
            int rp = (ph == 0) ? 25 : (ph == 1) ? 85 : 55;
            if (i % 70 == 0) begin
                bus.af_level = 5'($urandom_range(0, DEPTH));
                bus.ae_level = 5'($urandom_range(0, DEPTH));
            end
            rst = ($urandom_range(0, 299) == 0);
            drive($urandom_range(0, 99) < wp, $urandom_range(0, 99) < rp,
                  DW'($urandom), $urandom_range(0, 19) == 0);
            rst = 0;
        end

        // Reset at count 7 with both error flags set.
        bus.af_level = 5'd12; bus.ae_level = 5'd2;
        for (int i = 0; i < DEPTH + 1; i++) drive(1, 0, 8'h11, 0);
        for (int i = 0; i < DEPTH + 1; i++) drive(0, 1, 8'h00, 0);
        for (int i = 0; i < 7; i++) drive(1, 0, DW'(8'h20 + i), 0);
        chk("pre_rst_count_lit", int'(bus.count), 7);
        chk("pre_rst_err_lit", int'(bus.w_overflow) + int'(bus.r_underflow), 2);
        rst = 1;
        drive(1, 1, 8'h33, 0);
        rst = 0;
        chk("rst_count_lit", int'(bus.count), 0);
        chk("rst_err_lit", int'(bus.w_overflow) + int'(bus.r_underflow), 0);
        chk("rst_ptr_lit", int'(bus.w_ptr) + int'(bus.r_ptr), 0);
        chk("rst_data_lit", int'(bus.r_data), 0);
        drive(1, 0, 8'hA5, 0);
        drive(0, 1, 8'h00, 0);
        chk("post_rst_read_lit", int'(bus.r_data), 8'hA5);
        chk("post_rst_valid_lit", int'(bus.r_valid), 1);
        drive(0, 0, 8'h00, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
